// File: rtl/axi_write_router.sv
// AXI write-path router: one master, four slaves, one outstanding write.
// Decodes the target slave from the top two address bits and forwards AW to
// it. It then steers the write-data mux for the whole burst and returns the
// selected slave's B response. Disabled slaves are served by an internal
// DECERR sink, which swallows the burst and answers with bresp=2'b11.
module axi_write_router #(
    parameter int         ADDR_W = 32,
    parameter logic [3:0] SLV_EN = 4'b1111
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m_awvalid,
    output logic              m_awready,
    input  logic [ADDR_W-1:0] m_awaddr,
    input  logic              m_wvalid,
    input  logic              m_wlast,
    output logic              m_wready,
    output logic              m_bvalid,
    input  logic              m_bready,
    output logic [1:0]        m_bresp,
    output logic [3:0]        s_awvalid,
    input  logic [3:0]        s_awready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic [1:0]        s_wsel,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        s_bvalid,
    input  logic [7:0]        s_bresp,
    output logic [3:0]        s_bready
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_DATA     = 3'd2,
        ST_RESP     = 3'd3,
        ST_ERR_DATA = 3'd4,
        ST_ERR_RESP = 3'd5
    } state_t;

    state_t            state_q;
    logic [1:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        idx_s;
    logic              sel_bvalid_s;

    assign idx_s        = m_awaddr[ADDR_W-1 -: 2];
    assign sel_bvalid_s = s_bvalid[sel_q];

    // Transaction sequencing: latch target on AW accept, advance on each handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            addr_q  <= {ADDR_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m_awvalid) begin
                        sel_q   <= idx_s;
                        addr_q  <= m_awaddr;
                        state_q <= SLV_EN[idx_s] ? ST_ADDR : ST_ERR_DATA;
                    end
                end
                ST_ADDR: begin
                    if (s_awready[sel_q]) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_wvalid && wready && m_wlast) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (sel_bvalid_s && m_bready) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ERR_DATA: begin
                    if (m_wvalid && m_wlast) begin
                        state_q <= ST_ERR_RESP;
                    end
                end
                ST_ERR_RESP: begin
                    if (m_bready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake decode; W and B pass straight through while their phase is active.
    always_comb begin
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        s_awvalid = 4'b0000;
        s_awaddr  = {ADDR_W{1'b0}};
        s_wsel    = 2'b00;
        wvalid    = 1'b0;
        s_bready  = 4'b0000;
        if (rst_i) begin
            m_awready = 1'b0;
        end else begin
            s_awaddr = addr_q;
            s_wsel   = sel_q;
            case (state_q)
                ST_IDLE: begin
                    m_awready = 1'b1;
                end
                ST_ADDR: begin
                    s_awvalid = 4'b0001 << sel_q;
                end
                ST_DATA: begin
                    wvalid   = m_wvalid;
                    m_wready = wready;
                end
                ST_RESP: begin
                    m_bvalid = sel_bvalid_s;
                    m_bresp  = sel_bvalid_s ? s_bresp[{sel_q, 1'b0} +: 2] : 2'b00;
                    s_bready = {3'b000, m_bready} << sel_q;
                end
                ST_ERR_DATA: begin
                    m_wready = 1'b1;
                end
                ST_ERR_RESP: begin
                    m_bvalid = 1'b1;
                    m_bresp  = 2'b11;
                end
                default: begin
                    m_awready = 1'b0;
                end
            endcase
        end
    end

endmodule
